// File: rtl/relm_div_seq_if.sv
// Operand/result bundle for the relm_div_seq radix-8 restoring divider.
// The master drives the request side; the slave (the divider) drives results.
interface relm_div_seq_if #(
    parameter int WD = 32
);
    logic          start_in;
    logic [WD-1:0] n_in;
    logic [WD-1:0] d_in;
    logic          busy_out;
    logic          done_out;
    logic [WD-1:0] q_out;
    logic [WD-1:0] r_out;
    logic          dz_out;

    modport master (
        output start_in, n_in, d_in,
        input  busy_out, done_out, q_out, r_out, dz_out
    );

    modport slave (
        input  start_in, n_in, d_in,
        output busy_out, done_out, q_out, r_out, dz_out
    );
endinterface

// File: rtl/relm_div_seq.sv
// Sequential unsigned divider, three restoring steps per cycle (MSB first).
// Optional macro RELM_DIV_FASTPATH_EN: skip RUN when d_in==0 or d_in>n_in.
//
// state | meaning
// IDLE  | waiting for start_in, operands captured on accept
// RUN   | retiring 3 quotient bits per cycle
// DONE  | results valid, one-cycle done pulse
module relm_div_seq #(
    parameter int WD = 32
) (
    input logic            clk,
    input logic            rst_n,
    relm_div_seq_if.slave  dif
);
    localparam int NI = (WD + 2) / 3;
    localparam int NW = 3 * NI;
    localparam int CW = (NI > 1) ? $clog2(NI) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(NI - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q, state_nx;
    logic [NW-1:0] n_q;
    logic [WD-1:0] d_q;
    logic [WD-1:0] rem_q;
    logic [WD-1:0] q_acc;
    logic [CW-1:0] cnt_q;
    logic [WD-1:0] q_q, r_q;
    logic          dz_q;

    logic [WD:0]   step_s;
    logic [WD-1:0] rem_nx;
    logic [2:0]    qbit_nx;
    logic [WD+2:0] q_shift;
    logic [WD-1:0] q_nx;
    logic          fast;

`ifdef RELM_DIV_FASTPATH_EN
    assign fast = (dif.d_in == '0) || (dif.d_in > dif.n_in);
`else
    assign fast = 1'b0;
`endif

    // Three chained restoring steps; WD+1 bits so the shifted remainder fits.
    always_comb begin
        rem_nx  = rem_q;
        qbit_nx = '0;
        step_s  = '0;
        for (int i = 0; i < 3; i++) begin
            step_s = {rem_nx, n_q[NW-1-i]};
            if (step_s >= {1'b0, d_q}) begin
                step_s         = step_s - {1'b0, d_q};
                qbit_nx[2-i]   = 1'b1;
            end
            rem_nx = step_s[WD-1:0];
        end
        q_shift = {q_acc, qbit_nx};
        q_nx    = q_shift[WD-1:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_nx;
    end

    always_comb begin
        state_nx     = state_q;
        dif.busy_out = 1'b0;
        dif.done_out = 1'b0;
        case (state_q)
            IDLE: begin
                if (dif.start_in) state_nx = fast ? DONE : RUN;
            end
            RUN: begin
                dif.busy_out = 1'b1;
                if (cnt_q == '0) state_nx = DONE;
            end
            DONE: begin
                dif.busy_out = 1'b1;
                dif.done_out = 1'b1;
                state_nx     = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            n_q   <= '0;
            d_q   <= '0;
            rem_q <= '0;
            q_acc <= '0;
            cnt_q <= '0;
            q_q   <= '0;
            r_q   <= '0;
            dz_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (dif.start_in) begin
                    n_q   <= NW'(dif.n_in);
                    d_q   <= dif.d_in;
                    rem_q <= '0;
                    q_acc <= '0;
                    cnt_q <= CNT_LOAD;
                    if (fast) begin
                        q_q  <= (dif.d_in == '0) ? '1 : '0;
                        r_q  <= dif.n_in;
                        dz_q <= (dif.d_in == '0);
                    end
                end
                RUN: begin
                    n_q   <= n_q << 3;
                    rem_q <= rem_nx;
                    q_acc <= q_nx;
                    if (cnt_q == '0) begin
                        q_q  <= q_nx;
                        r_q  <= rem_nx;
                        dz_q <= (d_q == '0);
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign dif.q_out  = q_q;
    assign dif.r_out  = r_q;
    assign dif.dz_out = dz_q;
endmodule

// File: tb/tb_relm_div_seq.sv
// Scoreboard bench for relm_div_seq: expected results queued at launch,
// compared when done_out pulses.
module tb_relm_div_seq;
    localparam int WD = 32;

    typedef struct {
        logic [WD-1:0] q;
        logic [WD-1:0] r;
        logic          dz;
        int            lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    relm_div_seq_if #(.WD(WD)) dif ();
    relm_div_seq #(.WD(WD)) dut (.clk(clk), .rst_n(rst_n), .dif(dif.slave));

    always #5 clk = ~clk;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [WD-1:0] n, input logic [WD-1:0] d);
        exp_t e;
        bit   fast;
        if (d == '0) begin
            e.q = '1; e.r = n; e.dz = 1'b1;
        end else begin
            e.q = n / d; e.r = n % d; e.dz = 1'b0;
        end
        fast = 1'b0;
`ifdef RELM_DIV_FASTPATH_EN
        fast = (d == '0) || (d > n);
`endif
        e.lat = fast ? 1 : 12;
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [WD-1:0] n, input logic [WD-1:0] d);
        dif.start_in = 1'b1;
        dif.n_in     = n;
        dif.d_in     = d;
        sb.push_back(model(n, d));
        tick();
        dif.start_in = 1'b0;
        check_val("busy_after_accept", dif.busy_out, 1);
    endtask

    task automatic wait_result();
        exp_t e;
        int   lat;
        lat = 1;
        while (dif.done_out !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
        check_val("done_seen", dif.done_out, 1);
        if (sb.size() == 0) begin
            check_val("sb_nonempty", 0, 1);
        end else begin
            e = sb.pop_front();
            if (dif.done_out === 1'b1) begin
                check_val("q", dif.q_out, e.q);
                check_val("r", dif.r_out, e.r);
                check_val("dz", dif.dz_out, e.dz);
                check_val("latency", lat, e.lat);
            end
        end
        tick();
        check_val("done_one_cycle", dif.done_out, 0);
    endtask

    task automatic run_op(input logic [WD-1:0] n, input logic [WD-1:0] d);
        launch(n, d);
        wait_result();
    endtask

    initial begin
        int seen;
        logic [WD-1:0] rn, rd;

        dif.start_in = 1'b1;
        dif.n_in     = 32'd100;
        dif.d_in     = 32'd7;
        tick();
        tick();
        check_val("rst_busy", dif.busy_out, 0);
        check_val("rst_done", dif.done_out, 0);
        check_val("rst_q", dif.q_out, 0);
        check_val("rst_r", dif.r_out, 0);
        check_val("rst_dz", dif.dz_out, 0);
        dif.start_in = 1'b0;
        rst_n = 1'b1;
        tick();

        run_op(32'd100, 32'd7);
        run_op(32'hFFFF_FFFF, 32'd1);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op(32'd1234, 32'd0);
        run_op(32'd5, 32'd9);
        run_op(32'd0, 32'd3);
        run_op(32'd100, 32'd7);

        // start held high with new operands while RUN is in progress
        dif.start_in = 1'b1;
        dif.n_in     = 32'd100;
        dif.d_in     = 32'd7;
        sb.push_back(model(32'd100, 32'd7));
        tick();
        dif.n_in = 32'd999;
        dif.d_in = 32'd5;
        wait_result();
        check_val("idle_before_reaccept", dif.busy_out, 0);
        sb.push_back(model(32'd999, 32'd5));
        tick();
        dif.start_in = 1'b0;
        check_val("busy_after_reaccept", dif.busy_out, 1);
        wait_result();

        // one-cycle reset in the middle of RUN
        dif.start_in = 1'b1;
        dif.n_in     = 32'd50;
        dif.d_in     = 32'd3;
        tick();
        dif.start_in = 1'b0;
        repeat (5) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_val("abort_busy", dif.busy_out, 0);
        check_val("abort_done", dif.done_out, 0);
        check_val("abort_q", dif.q_out, 0);
        check_val("abort_r", dif.r_out, 0);
        check_val("abort_dz", dif.dz_out, 0);
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (dif.done_out === 1'b1) seen++;
        end
        check_val("abort_no_done", seen, 0);
        run_op(32'd100, 32'd7);

        for (int i = 0; i < 6; i++) begin
            rn = $urandom;
            rd = (i % 2 == 0) ? WD'($urandom_range(1, 50)) : $urandom;
            run_op(rn, rd);
        end

        check_val("sb_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
